// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register address width, control-bundle bit positions
// and immediate extension.
package mips_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    localparam int CTRL_MEMREAD_BIT = 0;

    localparam int IMM_W = 16;
    localparam int XLEN  = 32;

    function automatic logic [XLEN-1:0] ext_imm(input logic [IMM_W-1:0] imm, input logic sext);
        return {{(XLEN-IMM_W){sext & imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/id_operand_sel.sv
// One ID/EX source operand: forces $zero to 0 and, when ID_EX_BYPASS_EN is defined,
// selects same-cycle writeback data over the register file read.
module id_operand_sel
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [REG_AW-1:0] addr_i,
    input  logic [WIDTH-1:0]  rd_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [WIDTH-1:0]  wb_data_i,
    output logic [WIDTH-1:0]  opnd_o,
    output logic              wb_hit_o
);

    // A writeback to $zero never counts as a hit.
    assign wb_hit_o = wb_we_i && (wb_addr_i != REG_ZERO) && (wb_addr_i == addr_i);

`ifdef ID_EX_BYPASS_EN
    assign opnd_o = (addr_i == REG_ZERO) ? '0 : (wb_hit_o ? wb_data_i : rd_i);
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data_i;
    assign opnd_o = (addr_i == REG_ZERO) ? '0 : rd_i;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles, hold-time writeback refresh and flush.
// ID_EX_BYPASS_EN selects same-cycle writeback bypass; otherwise a matching write stalls the read.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CTRL_W   = 12,
    parameter int LOAD_BIT = CTRL_MEMREAD_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_sext,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [WIDTH-1:0]  rd1,
    input  logic [WIDTH-1:0]  rd2,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [WIDTH-1:0]  ex_a,
    output logic [WIDTH-1:0]  ex_b,
    output logic [WIDTH-1:0]  ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl
);

    logic              ex_valid_q, ex_valid_d;
    logic [WIDTH-1:0]  ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_imm_q, ex_imm_d;
    logic [REG_AW-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;

    logic [WIDTH-1:0]  opnd_a, opnd_b;
    logic              hit_a, hit_b;
    logic              load_use, raw_stall, accept, refresh_a, refresh_b;

    id_operand_sel #(.WIDTH(WIDTH)) u_sel_a (
        .addr_i(in_rs), .rd_i(rd1), .wb_we_i(wb_we), .wb_addr_i(wb_addr),
        .wb_data_i(wb_data), .opnd_o(opnd_a), .wb_hit_o(hit_a)
    );

    id_operand_sel #(.WIDTH(WIDTH)) u_sel_b (
        .addr_i(in_rt), .rd_i(rd2), .wb_we_i(wb_we), .wb_addr_i(wb_addr),
        .wb_data_i(wb_data), .opnd_o(opnd_b), .wb_hit_o(hit_b)
    );

`ifdef ID_EX_BYPASS_EN
    logic unused_hits;
    assign unused_hits = hit_a | hit_b;
    assign raw_stall   = 1'b0;
`else
    // Without the bypass the read is retried once the regfile write has landed.
    assign raw_stall   = hit_a | hit_b;
`endif

    assign load_use = ex_valid_q && ex_ctrl_q[LOAD_BIT] && (ex_rt_q != REG_ZERO)
                      && ((ex_rt_q == in_rs) || (ex_rt_q == in_rt));
    assign in_ready = (!ex_valid_q || ex_ready) && !load_use && !flush && !raw_stall;
    assign accept   = in_valid && in_ready;

    assign refresh_a = wb_we && (wb_addr != REG_ZERO) && (wb_addr == ex_rs_q);
    assign refresh_b = wb_we && (wb_addr != REG_ZERO) && (wb_addr == ex_rt_q);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_imm_d   = ex_imm_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_rd_d    = ex_rd_q;
        ex_ctrl_d  = ex_ctrl_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            ex_a_d     = opnd_a;
            ex_b_d     = opnd_b;
            ex_imm_d   = WIDTH'(ext_imm(in_imm, in_sext));
            ex_rs_d    = in_rs;
            ex_rt_d    = in_rt;
            ex_rd_d    = in_rd;
            ex_ctrl_d  = in_ctrl;
        end else if (ex_valid_q && !ex_ready) begin
            // Stalled entry picks up results that retire while it waits.
            if (refresh_a) ex_a_d = wb_data;
            if (refresh_b) ex_b_d = wb_data;
        end else begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_imm_q   <= ex_imm_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign ex_imm   = ex_imm_q;
    assign ex_rs    = ex_rs_q;
    assign ex_rt    = ex_rt_q;
    assign ex_rd    = ex_rd_q;
    assign ex_ctrl  = ex_ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions are pushed with hand-computed
// expectations and a negedge monitor compares each entry as execute consumes it.
`timescale 1ns/1ps
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0] in_imm = '0;
    logic        in_sext = 1'b0;
    logic [11:0] in_ctrl = '0;
    logic [31:0] rd1, rd2;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;
    logic        ex_valid;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [11:0] ex_ctrl;

`ifdef ID_EX_BYPASS_EN
    localparam int RAW_STALL = 0;
`else
    localparam int RAW_STALL = 1;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(32), .CTRL_W(12), .LOAD_BIT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_sext(in_sext), .in_ctrl(in_ctrl), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
    );

    // Register file model: asynchronous read, write on the rising edge, no internal bypass.
    logic [31:0] rf [32];
    assign rd1 = rf[in_rs];
    assign rd2 = rf[in_rt];
    always @(posedge clk) if (wb_we) rf[wb_addr] <= wb_data;

    typedef struct {
        logic [31:0] a, b, imm;
        logic [4:0]  rs, rt, rd;
        logic [11:0] ctrl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, b, imm, input logic [4:0] rs, rt, rd,
                                input logic [11:0] ctrl);
        exp_t e;
        e.a = a; e.b = b; e.imm = imm; e.rs = rs; e.rt = rt; e.rd = rd; e.ctrl = ctrl;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst && ex_valid && ex_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry: got ex_a=%0h ex_rd=%0d with empty scoreboard", ex_a, ex_rd);
            end else begin
                mon_e = sb.pop_front();
                chk("ex_a", 64'(ex_a), 64'(mon_e.a));
                chk("ex_b", 64'(ex_b), 64'(mon_e.b));
                chk("ex_imm", 64'(ex_imm), 64'(mon_e.imm));
                chk("ex_fields", 64'({ex_rs, ex_rt, ex_rd, ex_ctrl}),
                    64'({mon_e.rs, mon_e.rt, mon_e.rd, mon_e.ctrl}));
            end
        end
    end

    task automatic set_in(input logic [4:0] rs, rt, rd, input logic [15:0] imm,
                          input logic sext, input logic [11:0] ctrl);
        in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_sext = sext; in_ctrl = ctrl;
        in_valid = 1'b1;
    endtask

    task automatic set_wb(input logic [4:0] addr, input logic [31:0] data);
        wb_we = 1'b1; wb_addr = addr; wb_data = data;
    endtask

    // Holds in_valid until accepted; the writeback pulse lasts only the first cycle.
    task automatic send(input exp_t e, input int exp_stalls, input string name);
        int stalls = 0;
        @(negedge clk);
        while (!in_ready && stalls < 20) begin
            stalls++;
            @(posedge clk); #1;
            wb_we = 1'b0;
            @(negedge clk);
        end
        if (in_ready) sb.push_back(e);
        else chk({name, "_accept_timeout"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wb_we = 1'b0;
        chk({name, "_stall_cycles"}, 64'(stalls), 64'(exp_stalls));
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_ex_valid"}, 64'(ex_valid), 64'd0);
        chk({name, "_ex_a_b"}, {ex_a, ex_b}, 64'd0);
        chk({name, "_ex_imm"}, 64'(ex_imm), 64'd0);
        chk({name, "_ex_fields"}, 64'({ex_rs, ex_rt, ex_rd, ex_ctrl}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0] = 32'hFFFF_FFFF;
        rf[5] = 32'h0000_0011;

        // Power-on reset
        #12;
        chk_cleared("reset");
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        set_in(5'd1, 5'd2, 5'd3, 16'h0012, 1'b1, 12'h0A0);
        send(mk(32'h1001, 32'h1002, 32'h12, 5'd1, 5'd2, 5'd3, 12'h0A0), 0, "basic");
        set_in(5'd4, 5'd6, 5'd7, 16'h8000, 1'b0, 12'h002);
        send(mk(32'h1004, 32'h1006, 32'h8000, 5'd4, 5'd6, 5'd7, 12'h002), 0, "zext");

        // Same-cycle writeback on operand A, then on operand B
        set_in(5'd5, 5'd7, 5'd9, 16'h0001, 1'b1, 12'h000);
        set_wb(5'd5, 32'h0000_00AB);
        send(mk(32'hAB, 32'h1007, 32'h1, 5'd5, 5'd7, 5'd9, 12'h000), RAW_STALL, "wb_rs");
        set_in(5'd10, 5'd11, 5'd12, 16'hFFFF, 1'b0, 12'h000);
        set_wb(5'd11, 32'h0000_CAFE);
        send(mk(32'h100A, 32'hCAFE, 32'hFFFF, 5'd10, 5'd11, 5'd12, 12'h000), RAW_STALL, "wb_rt");

        // $zero forced to 0 even with a write to $zero in flight; sign-extended immediate
        set_in(5'd0, 5'd9, 5'd1, 16'h8000, 1'b1, 12'h004);
        set_wb(5'd0, 32'h1234_5678);
        send(mk(32'h0, 32'h1009, 32'hFFFF_8000, 5'd0, 5'd9, 5'd1, 12'h004), 0, "zero_sext");

        // Load-use: one bubble, then accept
        set_in(5'd1, 5'd8, 5'd8, 16'h0004, 1'b1, 12'h001);
        send(mk(32'h1001, 32'h1008, 32'h4, 5'd1, 5'd8, 5'd8, 12'h001), 0, "load");
        set_in(5'd8, 5'd2, 5'd4, 16'h0000, 1'b1, 12'h0A0);
        @(negedge clk);
        chk("lu_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("lu_bubble", 64'(ex_valid), 64'd0);
        send(mk(32'h1008, 32'h1002, 32'h0, 5'd8, 5'd2, 5'd4, 12'h0A0), 0, "lu_accept");

        // Load followed by an independent instruction: no bubble
        set_in(5'd2, 5'd12, 5'd12, 16'h0000, 1'b1, 12'h001);
        send(mk(32'h1002, 32'h100C, 32'h0, 5'd2, 5'd12, 5'd12, 12'h001), 0, "load2");
        set_in(5'd1, 5'd2, 5'd5, 16'h0000, 1'b1, 12'h000);
        send(mk(32'h1001, 32'h1002, 32'h0, 5'd1, 5'd2, 5'd5, 12'h000), 0, "indep");

        // Hold with refresh of operand A only
        @(posedge clk); #1;
        ex_ready = 1'b0;
        set_in(5'd3, 5'd4, 5'd5, 16'h0000, 1'b1, 12'h000);
        send(mk(32'h55, 32'h1004, 32'h0, 5'd3, 5'd4, 5'd5, 12'h000), 0, "hold");
        set_wb(5'd3, 32'h0000_0055);
        @(negedge clk);
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        wb_we = 1'b0;
        @(negedge clk);
        chk("hold_ex_valid", 64'(ex_valid), 64'd1);
        chk("refresh_ex_a", 64'(ex_a), 64'h55);
        chk("refresh_ex_b", 64'(ex_b), 64'h1004);
        ex_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Flush beats an incoming instruction
        set_in(5'd6, 5'd7, 5'd8, 16'h0000, 1'b1, 12'h000);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_ex_valid", 64'(ex_valid), 64'd0);

        // Asynchronous reset while a live entry is held
        @(posedge clk); #1;
        ex_ready = 1'b0;
        set_in(5'd6, 5'd7, 5'd8, 16'h0003, 1'b1, 12'h0FF);
        send(mk(32'h1006, 32'h1007, 32'h3, 5'd6, 5'd7, 5'd8, 12'h0FF), 0, "pre_reset");
        @(negedge clk);
        chk("pre_reset_ex_valid", 64'(ex_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk_cleared("mid_reset");
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        ex_ready = 1'b1;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
